// File: rtl/fifo_control_if.sv
// Control/status bundle between a FIFO controller (slave) and the producer/consumer
// logic that drives it (master); the storage array itself sits outside this bundle.
interface fifo_control_if #(
   parameter int address_width = 2
);
   logic                     init;
   logic                     push;
   logic                     pop;
   logic [address_width:0]   thr_high;
   logic [address_width:0]   thr_low;
   logic                     wr_enable;
   logic                     rd_enable;
   logic [address_width-1:0] wr_ptr;
   logic [address_width-1:0] rd_ptr;
   logic [address_width:0]   count;
   logic                     full;
   logic                     empty;
   logic                     almost_full;
   logic                     almost_empty;
   logic                     error;
   logic [2:0]               state;

   // Handshake: push/pop act as valid; wr_enable/rd_enable act as the same-cycle accept.
   // A request is taken only on a rising edge where its enable is high.
   modport master (
      output init, push, pop, thr_high, thr_low,
      input  wr_enable, rd_enable, wr_ptr, rd_ptr, count,
      input  full, empty, almost_full, almost_empty, error, state
   );

   modport slave (
      input  init, push, pop, thr_high, thr_low,
      output wr_enable, rd_enable, wr_ptr, rd_ptr, count,
      output full, empty, almost_full, almost_empty, error, state
   );
endinterface

// File: rtl/fifo_control.sv
// FIFO controller for an external 2**address_width-deep storage array: write/read strobes,
// addresses, occupancy, threshold flags and a sticky overflow/underflow error state.
module fifo_control #(
   parameter int data_width    = 6,
   parameter int address_width = 2
) (
   input  logic          clk,
   input  logic          reset,
   fifo_control_if.slave bus
);
   localparam int DEPTH = 2 ** address_width;
   localparam logic [address_width:0] FULL_COUNT = DEPTH[address_width:0];

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_INIT   = 3'd1,
      S_IDLE   = 3'd2,
      S_ACTIVE = 3'd3,
      S_ERROR  = 3'd4
   } state_t;

   state_t                   state_q, state_d;
   logic [address_width-1:0] wr_ptr_q, wr_ptr_d;
   logic [address_width-1:0] rd_ptr_q, rd_ptr_d;
   logic [address_width:0]   count_q, count_d;
   logic [address_width:0]   thr_high_q, thr_high_d;
   logic [address_width:0]   thr_low_q, thr_low_d;
   logic                     error_q, error_d;
   logic                     running, full, empty, wr_en, rd_en, overflow, underflow;

   if (data_width < 1) begin : g_width_check
      $error("fifo_control: data_width must be at least 1");
   end

   always_comb begin
      running   = (state_q == S_IDLE) || (state_q == S_ACTIVE);
      full      = (count_q == FULL_COUNT);
      empty     = (count_q == '0);
      wr_en     = bus.push && !full && running;
      rd_en     = bus.pop && !empty && running;
      overflow  = running && bus.push && full;
      underflow = running && bus.pop && empty;
   end

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      thr_high_d = thr_high_q;
      thr_low_d  = thr_low_q;
      error_d    = error_q;
      unique case (state_q)
         S_RESET: state_d = S_INIT;
         S_INIT: begin
            thr_high_d = bus.thr_high;
            thr_low_d  = bus.thr_low;
            if (!bus.init) state_d = (count_q == '0) ? S_IDLE : S_ACTIVE;
         end
         S_IDLE, S_ACTIVE: begin
            // An illegal request freezes pointers and count for the rest of the run.
            if (overflow || underflow) begin
               error_d = 1'b1;
               state_d = S_ERROR;
            end else begin
               if (wr_en) wr_ptr_d = wr_ptr_q + address_width'(1);
               if (rd_en) rd_ptr_d = rd_ptr_q + address_width'(1);
               if (wr_en && !rd_en)      count_d = count_q + (address_width + 1)'(1);
               else if (rd_en && !wr_en) count_d = count_q - (address_width + 1)'(1);
               if (bus.init) state_d = S_INIT;
               else          state_d = (count_d == '0) ? S_IDLE : S_ACTIVE;
            end
         end
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_ERROR;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_RESET;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         thr_high_q <= '0;
         thr_low_q  <= '0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         thr_high_q <= thr_high_d;
         thr_low_q  <= thr_low_d;
         error_q    <= error_d;
      end
   end

   assign bus.wr_enable    = wr_en;
   assign bus.rd_enable    = rd_en;
   assign bus.wr_ptr       = wr_ptr_q;
   assign bus.rd_ptr       = rd_ptr_q;
   assign bus.count        = count_q;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= thr_high_q);
   assign bus.almost_empty = (count_q <= thr_low_q);
   assign bus.error        = error_q;
   assign bus.state        = state_q;
endmodule

// File: tb/tb_fifo_control.sv
// Bench for fifo_control: directed scenarios plus randomized push/pop traffic checked
// against an occupancy/queue reference model and a small storage array.
module tb_fifo_control;
   localparam int DW    = 6;
   localparam int AW    = 2;
   localparam int DEPTH = 4;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   fifo_control_if #(.address_width(AW)) bus ();
   fifo_control #(.data_width(DW), .address_width(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Storage array paired with the controller: read data is registered on rd_enable.
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rd_data;
   logic [DW-1:0] wr_data;
   always @(posedge clk) begin
      if (bus.wr_enable) mem[bus.wr_ptr] <= wr_data;
      if (bus.rd_enable) rd_data <= mem[bus.rd_ptr];
   end

   int            m_state, m_count, m_wr, m_rd, m_thh, m_thl;
   bit            m_err;
   bit            exp_we, exp_re, seen_we, seen_re, got_read;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] want_data;

   function automatic void model_reset();
      m_state = 0; m_count = 0; m_wr = 0; m_rd = 0; m_thh = 0; m_thl = 0; m_err = 0;
      exp_q.delete();
   endfunction

   task automatic hold_reset();
      reset = 1'b0;
      bus.init = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
      bus.thr_high = '0; bus.thr_low = '0;
      model_reset();
      repeat (2) @(negedge clk);
   endtask

   // One clock: drive requests at the negedge, sample enables, step the model, end on the next negedge.
   task automatic tick(input bit p, input bit q, input bit in);
      bit running, bad;
      bus.push = p; bus.pop = q; bus.init = in;
      wr_data = DW'($urandom);
      #1;
      seen_we = bus.wr_enable;
      seen_re = bus.rd_enable;
      running = (m_state == 2) || (m_state == 3);
      exp_we  = p && running && (m_count < DEPTH);
      exp_re  = q && running && (m_count > 0);
      bad     = running && ((p && m_count == DEPTH) || (q && m_count == 0));
      if (exp_we && !bad) exp_q.push_back(wr_data);
      @(posedge clk);
      case (m_state)
         0: m_state = 1;
         1: begin
            m_thh = int'(bus.thr_high);
            m_thl = int'(bus.thr_low);
            if (!in) m_state = (m_count == 0) ? 2 : 3;
         end
         2, 3: begin
            if (bad) begin
               m_err = 1; m_state = 4;
            end else begin
               m_count = m_count + int'(exp_we) - int'(exp_re);
               m_wr    = (m_wr + int'(exp_we)) % DEPTH;
               m_rd    = (m_rd + int'(exp_re)) % DEPTH;
               m_state = in ? 1 : ((m_count > 0) ? 3 : 2);
            end
         end
         default: ;
      endcase
      got_read = exp_re && !bad;
      if (got_read) want_data = exp_q.pop_front();
      @(negedge clk);
   endtask

   task automatic bring_up(input int thh, input int thl);
      bus.thr_high = (AW+1)'(thh);
      bus.thr_low  = (AW+1)'(thl);
      reset = 1'b1;
      tick(0, 0, 1);
      tick(0, 0, 1);
      tick(0, 0, 0);
   endtask

   task automatic test_reset();
      hold_reset();
      checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state); end
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
      checks++; if ({bus.wr_ptr, bus.rd_ptr} !== 4'd0) begin errors++; $display("FAIL reset_ptrs: got wr %0d rd %0d want 0 0", bus.wr_ptr, bus.rd_ptr); end
      checks++; if ({bus.empty, bus.full, bus.error} !== 3'b100) begin errors++; $display("FAIL reset_flags: got empty/full/error %b want 100", {bus.empty, bus.full, bus.error}); end
      bus.push = 1'b1; bus.pop = 1'b1; #1;
      checks++; if ({bus.wr_enable, bus.rd_enable} !== 2'b00) begin errors++; $display("FAIL reset_enables: got %b want 00", {bus.wr_enable, bus.rd_enable}); end
      bus.push = 1'b0; bus.pop = 1'b0;
   endtask

   task automatic test_init();
      bus.thr_high = 3'd3; bus.thr_low = 3'd1;
      reset = 1'b1;
      tick(0, 0, 1);
      checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL init_first: got %0d want 1", bus.state); end
      tick(0, 0, 1);
      checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL init_hold: got %0d want 1", bus.state); end
      tick(0, 0, 0);
      checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL init_idle: got %0d want 2", bus.state); end
      checks++; if ({bus.empty, bus.almost_empty, bus.almost_full} !== 3'b110) begin errors++; $display("FAIL init_flags: got empty/ae/af %b want 110", {bus.empty, bus.almost_empty, bus.almost_full}); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         tick(1, 0, 0);
         checks++; if (seen_we !== 1'b1) begin errors++; $display("FAIL fill_we[%0d]: got %0d want 1", i, seen_we); end
         checks++; if (bus.wr_ptr !== AW'((i + 1) % 4)) begin errors++; $display("FAIL fill_wr_ptr[%0d]: got %0d want %0d", i, bus.wr_ptr, (i + 1) % 4); end
         checks++; if (bus.almost_full !== (i >= 2)) begin errors++; $display("FAIL fill_af[%0d]: got %0d want %0d", i, bus.almost_full, i >= 2); end
      end
      checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", bus.count); end
      checks++; if ({bus.full, bus.error, bus.state} !== {1'b1, 1'b0, 3'd3}) begin errors++; $display("FAIL fill_status: got full %0d error %0d state %0d want 1 0 3", bus.full, bus.error, bus.state); end
   endtask

   task automatic test_overflow();
      tick(1, 0, 0);
      checks++; if (seen_we !== 1'b0) begin errors++; $display("FAIL ovf_we: got %0d want 0", seen_we); end
      checks++; if ({bus.error, bus.state, bus.count} !== {1'b1, 3'd4, 3'd4}) begin errors++; $display("FAIL ovf_status: got error %0d state %0d count %0d want 1 4 4", bus.error, bus.state, bus.count); end
      for (int i = 0; i < 4; i++) begin
         tick(1'($urandom), 1'($urandom), 0);
         checks++; if ({seen_we, seen_re} !== 2'b00) begin errors++; $display("FAIL ovf_ignore_en[%0d]: got %b want 00", i, {seen_we, seen_re}); end
         checks++; if ({bus.state, bus.count, bus.wr_ptr, bus.rd_ptr} !== {3'd4, 3'd4, 2'd0, 2'd0}) begin errors++; $display("FAIL ovf_frozen[%0d]: got state %0d count %0d wr %0d rd %0d want 4 4 0 0", i, bus.state, bus.count, bus.wr_ptr, bus.rd_ptr); end
      end
   endtask

   task automatic test_back_to_back();
      hold_reset();
      bring_up(3, 1);
      tick(1, 0, 0);
      tick(1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick(1, 1, 0);
         checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL b2b_count[%0d]: got %0d want 2", i, bus.count); end
         checks++; if (bus.wr_ptr !== AW'((3 + i) % 4) || bus.rd_ptr !== AW'(1 + i)) begin errors++; $display("FAIL b2b_ptrs[%0d]: got wr %0d rd %0d want %0d %0d", i, bus.wr_ptr, bus.rd_ptr, (3 + i) % 4, 1 + i); end
         checks++; if (!got_read || rd_data !== want_data) begin errors++; $display("FAIL b2b_data[%0d]: got %0d want %0d", i, rd_data, want_data); end
      end
      for (int i = 0; i < 2; i++) begin
         tick(0, 1, 0);
         checks++; if (!got_read || rd_data !== want_data) begin errors++; $display("FAIL b2b_drain[%0d]: got %0d want %0d", i, rd_data, want_data); end
      end
      checks++; if ({bus.empty, bus.state} !== {1'b1, 3'd2}) begin errors++; $display("FAIL b2b_end: got empty %0d state %0d want 1 2", bus.empty, bus.state); end
   endtask

   task automatic test_underflow();
      hold_reset();
      bring_up(3, 1);
      tick(0, 1, 0);
      checks++; if (seen_re !== 1'b0) begin errors++; $display("FAIL udf_re: got %0d want 0", seen_re); end
      checks++; if ({bus.error, bus.state, bus.count} !== {1'b1, 3'd4, 3'd0}) begin errors++; $display("FAIL udf_status: got error %0d state %0d count %0d want 1 4 0", bus.error, bus.state, bus.count); end
   endtask

   task automatic test_async_reset();
      hold_reset();
      bring_up(3, 1);
      repeat (3) tick(1, 0, 0);
      checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL areset_pre: got %0d want 3", bus.count); end
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checks++; if ({bus.state, bus.count, bus.wr_ptr, bus.rd_ptr} !== 10'd0) begin errors++; $display("FAIL areset_regs: got state %0d count %0d wr %0d rd %0d want 0 0 0 0", bus.state, bus.count, bus.wr_ptr, bus.rd_ptr); end
      checks++; if ({bus.empty, bus.full, bus.error, bus.wr_enable, bus.rd_enable} !== 5'b10000) begin errors++; $display("FAIL areset_flags: got %b want 10000", {bus.empty, bus.full, bus.error, bus.wr_enable, bus.rd_enable}); end
      @(negedge clk);
   endtask

   task automatic test_random();
      bit p, q, in;
      for (int ep = 0; ep < 6; ep++) begin
         hold_reset();
         bring_up($urandom_range(0, DEPTH), $urandom_range(0, DEPTH));
         for (int c = 0; c < 50; c++) begin
            p  = 1'($urandom_range(0, 1));
            q  = 1'($urandom_range(0, 1));
            in = ($urandom_range(0, 19) == 0);
            if (in) begin p = 0; q = 0; end
            if (p && m_count == DEPTH && $urandom_range(0, 15) != 0) p = 0;
            if (q && m_count == 0 && $urandom_range(0, 15) != 0) q = 0;
            bus.thr_high = (AW+1)'($urandom_range(0, DEPTH));
            bus.thr_low  = (AW+1)'($urandom_range(0, DEPTH));
            tick(p, q, in);
            checks++; if ({seen_we, seen_re} !== {exp_we, exp_re}) begin errors++; $display("FAIL rnd_en[%0d.%0d]: got %b want %b", ep, c, {seen_we, seen_re}, {exp_we, exp_re}); end
            checks++; if (bus.state !== 3'(m_state) || bus.error !== m_err) begin errors++; $display("FAIL rnd_state[%0d.%0d]: got %0d/%0d want %0d/%0d", ep, c, bus.state, bus.error, m_state, m_err); end
            checks++; if (bus.count !== (AW+1)'(m_count) || bus.wr_ptr !== AW'(m_wr) || bus.rd_ptr !== AW'(m_rd)) begin errors++; $display("FAIL rnd_occ[%0d.%0d]: got count %0d wr %0d rd %0d want %0d %0d %0d", ep, c, bus.count, bus.wr_ptr, bus.rd_ptr, m_count, m_wr, m_rd); end
            checks++; if ({bus.full, bus.empty, bus.almost_full, bus.almost_empty} !== {m_count == DEPTH, m_count == 0, m_count >= m_thh, m_count <= m_thl}) begin errors++; $display("FAIL rnd_flags[%0d.%0d]: got %b count %0d thh %0d thl %0d", ep, c, {bus.full, bus.empty, bus.almost_full, bus.almost_empty}, m_count, m_thh, m_thl); end
            if (got_read) begin
               checks++; if (rd_data !== want_data) begin errors++; $display("FAIL rnd_data[%0d.%0d]: got %0d want %0d", ep, c, rd_data, want_data); end
            end
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      test_reset();
      test_init();
      test_fill();
      test_overflow();
      test_back_to_back();
      test_underflow();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fifo_control.md
FIFO_CONTROL -- requirements
Module: fifo_control

Interface
REQ-001 The block SHALL have parameter data_width, default 6, meaning the word width of the paired storage array (this block passes no data).
REQ-002 The block SHALL have parameter address_width, default 2, meaning pointer width; depth DEPTH = 2**address_width (default 4).
REQ-003 Port clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-004 Port reset  input  1  is the asynchronous, active-low reset.
REQ-005 Port init  input  1  requests threshold reload (synchronous).
REQ-006 Port push  input  1  is the producer write request.
REQ-007 Port pop  input  1  is the consumer read request.
REQ-008 Port thr_high  input  address_width+1  is the almost-full threshold, sampled in state INIT.
REQ-009 Port thr_low  input  address_width+1  is the almost-empty threshold, sampled in state INIT.
REQ-010 Port wr_enable  output  1  is the write strobe to the storage array.
REQ-011 Port rd_enable  output  1  is the read strobe to the storage array.
REQ-012 Port wr_ptr  output  address_width  is the write address.
REQ-013 Port rd_ptr  output  address_width  is the read address.
REQ-014 Port count  output  address_width+1  is the current occupancy, 0..DEPTH.
REQ-015 Port full, empty, almost_full, almost_empty, error  output  1 each  are status flags.
REQ-016 Port state  output  3  is the encoded FSM state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.

Function
REQ-017 The FSM SHALL transition RESET->INIT on the first clock after reset deasserts.
REQ-018 In INIT, the FSM SHALL register thr_high/thr_low every cycle and move to IDLE when init=0.
REQ-019 In IDLE or ACTIVE, init=1 SHALL return the FSM to INIT without touching pointers or count.
REQ-020 The FSM SHALL be in IDLE when count=0 and no error has occurred, ACTIVE when count>0, and ERROR after any overflow or underflow attempt; ERROR is left only by reset.
REQ-021 wr_enable SHALL be combinational: push & !full & (state is IDLE or ACTIVE).
REQ-022 rd_enable SHALL be combinational: pop & !empty & (state is IDLE or ACTIVE).
REQ-023 On a clock edge with wr_enable=1, wr_ptr SHALL increment modulo DEPTH (3->0 wrap); with rd_enable=1, rd_ptr SHALL increment modulo DEPTH.
REQ-024 count SHALL be +1 on write only, -1 on read only, and unchanged on a simultaneous write and read.
REQ-025 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both combinational from registered count.
REQ-026 almost_full SHALL equal (count>=thr_high registered) and almost_empty SHALL equal (count<=thr_low registered).
REQ-027 When full, push SHALL be rejected even if pop is accepted in the same cycle; when empty, pop SHALL be rejected even if push is accepted.
REQ-028 A push while full or a pop while empty SHALL set error (sticky) on the next edge, enter ERROR, and leave pointers and count unchanged.
REQ-029 In ERROR, in RESET, and in INIT, wr_enable and rd_enable SHALL be 0.
REQ-030 Read data appears at the storage output one clock after rd_enable; the controller adds no further latency.

Reset
REQ-031 While reset=0, regardless of clk: wr_ptr=0, rd_ptr=0, count=0, error=0, state=RESET, registered thresholds=0, wr_enable=0, rd_enable=0, empty=1, full=0.
REQ-032 Reset asserted mid-operation SHALL discard occupancy immediately; stored words are considered lost.

Verification
REQ-033 Reset, init=1 for 2 cycles with thr_high=3 and thr_low=1, then init=0 -> state goes 0->1->2; empty=1 and almost_empty=1.
REQ-034 Four pushes -> wr_ptr 1,2,3,0; count=4; full=1; almost_full=1 after the third push; error=0.
REQ-035 A fifth push while full -> wr_enable=0, error=1, state=4, count stays 4, and later push/pop are ignored.
REQ-036 After reset, 2 pushes, then push+pop for 3 cycles -> count stays 2, both pointers wrap correctly, and the data order matches against a scoreboard.
REQ-037 A pop on an empty FIFO directly after INIT -> rd_enable=0, error=1, state=4.
REQ-038 Drop reset to 0 at count=3 -> all outputs reach reset values within the same cycle without waiting for a clock edge.
